// File: rtl/sys_mem_ctrl.sv
// Sequencer for the 64x8 byte memory: byte/word CPU requests become timed byte accesses; MEM_WR_VERIFY_EN adds read-back checking of writes.
// Latency: byte rd RD_HOLD, word rd 4*RD_HOLD, byte wr WR_HOLD+1, word wr 4*(WR_HOLD+1), erase 2 (+RD_HOLD per written byte with verify).
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module sys_mem_ctrl #(
  parameter int RD_HOLD = 3,
  parameter int WR_HOLD = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_word,
  input  logic [5:0]  req_adrs,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [5:0]  mem_adrs,
  output logic        mem_mode,
  output logic [7:0]  mem_data,
  output logic        mem_erase,
  input  logic [7:0]  mem_out
);

  typedef enum logic [2:0] {IDLE, RD, WR, ER, RESP, VR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        word_q, word_nxt;
  logic [5:0]  base, base_nxt;
  logic [31:0] wdata_q, wdata_nxt;

  logic        req_ready_nxt;
  logic        rsp_valid_nxt;
  logic [31:0] rsp_data_nxt;
  logic        rsp_err_nxt;
  logic [5:0]  mem_adrs_nxt;
  logic        mem_mode_nxt;
  logic [7:0]  mem_data_nxt;
  logic        mem_erase_nxt;

  logic        accept;
  logic        last_byte;
  logic        rd_last;
  logic        wr_last;
  logic        gap_last;
  logic [1:0]  idx_inc;
  logic [5:0]  adrs_inc;

  assign accept    = req_valid && req_ready;
  assign last_byte = !word_q || (idx == 2'd3);
  assign rd_last   = (cnt == 4'(RD_HOLD - 1));
  assign wr_last   = (cnt == 4'(WR_HOLD - 1));
  assign gap_last  = (cnt == 4'(WR_HOLD));
  assign idx_inc   = idx + 2'd1;
  // 6-bit add wraps 63 -> 0 for word accesses near the top
  assign adrs_inc  = base + {4'd0, idx_inc};

`ifdef MEM_WR_VERIFY_EN
  logic [7:0] wbyte;
  assign wbyte = wdata_q[{idx, 3'b000} +: 8];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      word_q    <= 1'b0;
      base      <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mem_adrs  <= '0;
      mem_mode  <= 1'b0;
      mem_data  <= '0;
      mem_erase <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      word_q    <= word_nxt;
      base      <= base_nxt;
      wdata_q   <= wdata_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      mem_adrs  <= mem_adrs_nxt;
      mem_mode  <= mem_mode_nxt;
      mem_data  <= mem_data_nxt;
      mem_erase <= mem_erase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (req_op)
            2'b00:   state_nxt = RD;
            2'b01:   state_nxt = WR;
            2'b10:   state_nxt = ER;
            default: state_nxt = RESP;
          endcase
        end
      end
      RD: begin
        if (rd_last && last_byte) state_nxt = RESP;
      end
      WR: begin
        if (gap_last) begin
`ifdef MEM_WR_VERIFY_EN
          state_nxt = VR;
`else
          if (last_byte) state_nxt = RESP;
`endif
        end
      end
      VR: begin
        if (rd_last) state_nxt = last_byte ? RESP : WR;
      end
      ER: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    word_nxt      = word_q;
    base_nxt      = base;
    wdata_nxt     = wdata_q;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    mem_adrs_nxt  = mem_adrs;
    mem_mode_nxt  = 1'b0;
    mem_data_nxt  = mem_data;
    mem_erase_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (accept) begin
          req_ready_nxt = 1'b0;
          word_nxt      = req_word;
          base_nxt      = req_adrs;
          wdata_nxt     = req_wdata;
          idx_nxt       = '0;
          cnt_nxt       = '0;
          mem_adrs_nxt  = req_adrs;
          rsp_data_nxt  = '0;
          rsp_err_nxt   = 1'b0;
          unique case (req_op)
            2'b00: ;
            2'b01: begin
              mem_mode_nxt = 1'b1;
              mem_data_nxt = req_wdata[7:0];
            end
            2'b10: mem_erase_nxt = 1'b1;
            default: begin
              rsp_valid_nxt = 1'b1;
              rsp_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      RD: begin
        cnt_nxt = cnt + 4'd1;
        if (rd_last) begin
          cnt_nxt = '0;
          rsp_data_nxt[{idx, 3'b000} +: 8] = mem_out;
          if (last_byte) begin
            rsp_valid_nxt = 1'b1;
          end else begin
            idx_nxt      = idx_inc;
            mem_adrs_nxt = adrs_inc;
          end
        end
      end
      WR: begin
        cnt_nxt      = cnt + 4'd1;
        // mode drops one cycle early so the next address never sees a write strobe
        mem_mode_nxt = !(wr_last || gap_last);
        if (gap_last) begin
          cnt_nxt = '0;
`ifndef MEM_WR_VERIFY_EN
          if (last_byte) begin
            rsp_valid_nxt = 1'b1;
          end else begin
            idx_nxt      = idx_inc;
            mem_adrs_nxt = adrs_inc;
            mem_mode_nxt = 1'b1;
            mem_data_nxt = wdata_q[{idx_inc, 3'b000} +: 8];
          end
`endif
        end
      end
      VR: begin
        cnt_nxt = cnt + 4'd1;
        if (rd_last) begin
          cnt_nxt = '0;
`ifdef MEM_WR_VERIFY_EN
          if (mem_out != wbyte) rsp_err_nxt = 1'b1;
`endif
          if (last_byte) begin
            rsp_valid_nxt = 1'b1;
          end else begin
            idx_nxt      = idx_inc;
            mem_adrs_nxt = adrs_inc;
            mem_mode_nxt = 1'b1;
            mem_data_nxt = wdata_q[{idx_inc, 3'b000} +: 8];
          end
        end
      end
      ER: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd1) rsp_valid_nxt = 1'b1;
      end
      RESP: begin
        if (rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Bench for sys_mem_ctrl: behavioural 64x8 memory with 2-cycle read latency, transaction-level reference model.
`timescale 1ns/1ps
module tb_sys_mem_ctrl;

  localparam int RDH = 3;
  localparam int WRH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_word = 1'b0;
  logic [5:0]  req_adrs = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [5:0]  mem_adrs;
  logic        mem_mode;
  logic [7:0]  mem_data;
  logic        mem_erase;
  logic [7:0]  mem_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sys_mem_ctrl #(.RD_HOLD(RDH), .WR_HOLD(WRH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_adrs(mem_adrs), .mem_mode(mem_mode), .mem_data(mem_data), .mem_erase(mem_erase),
    .mem_out(mem_out)
  );

  // memory device: two registered read stages, write on mode, erase clears everything
  logic [7:0] dev_mem [64];
  logic [7:0] pipe1, pipe2;
  logic       ld_en = 1'b0;
  logic [5:0] ld_adrs = '0;
  logic [7:0] ld_dat = '0;
  assign mem_out = pipe2;

  always @(posedge clk) begin
    pipe1 <= dev_mem[mem_adrs];
    pipe2 <= pipe1;
    if (mem_erase) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= 8'h00;
    end else if (mem_mode) begin
      dev_mem[mem_adrs] <= mem_data;
    end
    if (ld_en) dev_mem[ld_adrs] <= ld_dat;
  end

  logic [7:0] ref_mem [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_adrs = a; ld_dat = d;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_req(input logic [1:0] op, input logic w, input logic [5:0] a,
                        input logic [31:0] wd, input int stall, input string tag,
                        output logic [31:0] d, output logic e, output int lat,
                        output int nm, output int ne);
    int guard;
    logic [31:0] held;
    d = '0; e = 1'b0; lat = -1; nm = 0; ne = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_word = w; req_adrs = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      nm += int'(mem_mode);
      ne += int'(mem_erase);
      if (rsp_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
      return;
    end
    d = rsp_data;
    e = rsp_err;
    held = rsp_data;
    if (stall > 0) begin
      req_valid = 1'b1; req_op = 2'b00;
      for (int c = 0; c < stall; c++) begin
        @(posedge clk);
        #1;
        check({tag, "_stall_state"}, {rsp_valid, req_ready, mem_mode, mem_erase, rsp_data},
              {1'b1, 1'b0, 1'b0, 1'b0, held});
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_clear"}, {rsp_valid, req_ready}, 2'b00);
  endtask

  // reference: compute expected outcome from the shadow memory, then apply the request to it
  task automatic run_check(input logic [1:0] op, input logic w, input logic [5:0] a,
                           input logic [31:0] wd, input int stall, input string tag);
    int n, elat, emode, eer;
    logic [31:0] ed, d;
    logic ee, e;
    int lat, nm, ne;
    n = w ? 4 : 1;
    ed = '0; ee = 1'b0; emode = 0; eer = 0;
    case (op)
      2'b00: begin
        for (int i = 0; i < n; i++) ed |= 32'(ref_mem[6'(int'(a) + i)]) << (8 * i);
        elat = RDH * n;
      end
      2'b01: begin
`ifdef MEM_WR_VERIFY_EN
        elat = (WRH + 1 + RDH) * n;
`else
        elat = (WRH + 1) * n;
`endif
        emode = WRH * n;
      end
      2'b10: begin elat = 2; eer = 1; end
      default: begin elat = 0; ee = 1'b1; end
    endcase
    do_req(op, w, a, wd, stall, tag, d, e, lat, nm, ne);
    check({tag, "_data"}, 64'(d), 64'(ed));
    check({tag, "_err"}, 64'(e), 64'(ee));
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_modecyc"}, 64'(nm), 64'(emode));
    check({tag, "_erasecyc"}, 64'(ne), 64'(eer));
    if (op == 2'b01) begin
      for (int i = 0; i < n; i++) ref_mem[6'(int'(a) + i)] = wd[8*i +: 8];
    end else if (op == 2'b10) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    end
  endtask

  initial begin
    logic [1:0] op;
    int r;
    // preload memory while reset is held
    for (int i = 0; i < 64; i++) load(6'(i), 8'($urandom));
    #1;
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_data, rsp_err, mem_adrs, mem_mode, mem_data, mem_erase}, '0);
    load(6'd0, 8'h07); load(6'd1, 8'h06); load(6'd2, 8'h09); load(6'd3, 8'h03);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_rises", 64'(req_ready), 64'd1);

    run_check(2'b00, 1'b1, 6'd0, '0, 0, "wrd_rd0");
    check("wrd_rd0_const", 64'(ref_mem[0] | (ref_mem[3] << 24)), 64'h03000007);
    run_check(2'b01, 1'b0, 6'd13, 32'h000000A5, 0, "byte_wr13");
    run_check(2'b00, 1'b0, 6'd13, '0, 0, "byte_rd13");
    run_check(2'b00, 1'b1, 6'd12, '0, 0, "wrd_rd12");
    run_check(2'b01, 1'b1, 6'd62, 32'hDEADBEEF, 0, "wrd_wr62");
    check("wrap_b62", 64'(dev_mem[62]), 64'hEF);
    check("wrap_b63", 64'(dev_mem[63]), 64'hBE);
    check("wrap_b0",  64'(dev_mem[0]),  64'hAD);
    check("wrap_b1",  64'(dev_mem[1]),  64'hDE);
    run_check(2'b00, 1'b1, 6'd62, '0, 0, "wrd_rd62");
    run_check(2'b10, 1'b0, 6'd5, '0, 0, "erase");
    run_check(2'b00, 1'b1, 6'd0, '0, 0, "rd_after_erase");
    run_check(2'b01, 1'b1, 6'd8, 32'h12345678, 0, "wr8");
    run_check(2'b00, 1'b1, 6'd8, '0, 5, "stall_rd8");
    run_check(2'b11, 1'b0, 6'd9, 32'hFFFFFFFF, 0, "reserved");

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 9) op = 2'b00;
      else if (r < 17) op = 2'b01;
      else if (r < 18) op = 2'b10;
      else op = 2'b11;
      run_check(op, 1'($urandom), 6'($urandom), $urandom, int'($urandom_range(0, 2)),
                $sformatf("rnd%0d", k));
    end

    // reset during the second byte of a word write at 20..23; those bytes are left unchecked
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_word = 1'b1; req_adrs = 6'd20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_wr_busy", 64'(mem_mode), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset",
          {req_ready, rsp_valid, rsp_data, rsp_err, mem_adrs, mem_mode, mem_data, mem_erase}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_check(2'b00, 1'b0, 6'd40, '0, 0, "post_reset_rd40");
    run_check(2'b00, 1'b1, 6'd30, '0, 0, "post_reset_rd30");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sys_mem_ctrl.md
Name: sys_mem_ctrl

Overview:
- Initiator/sequencer for the 64x8 byte memory: the side that drives its adrs/mode/data/erase pins and samples its out pin.
- Takes byte or 32-bit word requests from a CPU-side valid/ready interface.
- Holds address, mode and data stable for each memory access timing, then returns read data or a write/erase acknowledgement.
- Word accesses become four sequential byte accesses, assembled little-endian.

Parameters:
- RD_HOLD, 3: cycles mem_adrs/mem_mode=0 are held per byte read. Two cycles of memory latency plus one capture edge.
- WR_HOLD, 3: cycles mem_adrs/mem_data/mem_mode=1 are held per byte write.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready at a clk edge
- req_op  input  2  00 read, 01 write, 10 erase, 11 reserved
- req_word  input  1  1 = 32-bit word access, 0 = byte access
- req_adrs  input  6  byte address (word: base byte address)
- req_wdata  input  32  write data (byte access uses [7:0])
- rsp_valid  output  1  response present; held until rsp_ready
- rsp_ready  input  1  response consumed
- rsp_data  output  32  read data (byte reads zero-extended); 0 for write/erase
- rsp_err  output  1  response error flag
- mem_adrs  output  6  to memory adrs
- mem_mode  output  1  to memory mode (0 read, 1 write)
- mem_data  output  8  to memory data
- mem_erase  output  1  to memory erase
- mem_out  input  8  from memory out

Behaviour:
- All outputs are registered. Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_adrs=0, mem_mode=0, mem_data=0, mem_erase=0, state=IDLE.
- States:
  - IDLE
  - RD: per-byte counter 0..RD_HOLD-1
  - WR: counter 0..WR_HOLD-1
  - ER
  - RESP
- IDLE:
  - req_ready=1 only here; the first cycle after reset release it is 0 and then rises.
  - On accept, latch op/word/adrs/wdata, clear byte index, drive mem_adrs=req_adrs and go to RD, WR or ER.
  - Reserved op: go directly to RESP with rsp_err=1.
  - req_ready deasserts the cycle after accept.
- RD:
  - mem_mode=0; mem_adrs is held RD_HOLD cycles.
  - On the last edge, capture mem_out into byte lane [index] of rsp_data.
  - Byte access, or index=3: go to RESP.
  - Otherwise: index+1, mem_adrs=base+index+1 (mod 64, wraps 63->0), and the counter restarts.
- WR:
  - mem_mode=1, mem_data=wdata byte [index], held WR_HOLD cycles.
  - On the last edge, mem_mode returns to 0 for at least one cycle before the next byte begins (prevents a stray write to the next address).
  - Word writes advance index and address as in RD.
- ER: mem_erase=1 for exactly one cycle, then RESP with rsp_data=0.
- RESP:
  - rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready is sampled high.
  - Then clear rsp_valid and return to IDLE. No new request is accepted in the same edge.
- Latency from the accept edge to rsp_valid visible:
  - byte read: RD_HOLD cycles (3)
  - word read: 4*RD_HOLD (12)
  - byte write: WR_HOLD+1 (4)
  - word write: 4*(WR_HOLD+1) (16)
  - erase: 2
- mem_mode=0 and mem_erase=0 in every state other than WR and ER, so idle cycles only perform harmless reads.
- Async reset mid-operation forces reset values immediately. An interrupted write may or may not update the addressed memory word; no recovery is attempted.

Optional Feature:
- MEM_WR_VERIFY_EN defined:
  - After each byte write (including the mode=0 gap), the same address is read back for RD_HOLD cycles and compared with the written byte.
  - Any mismatch sets rsp_err=1 for that request. The remaining bytes are still written.
  - Added latency: RD_HOLD per byte.
- Not defined: no read-back; rsp_err is set only for the reserved op.

Test Plan:
- Reset, then word read at adrs 0 with memory word 0 preloaded 0x03090607 -> rsp_valid 12 cycles after accept, rsp_data=0x03090607, rsp_err=0.
- Byte write 0xA5 at adrs 13, then byte read at adrs 13 -> read response rsp_data=0x000000A5. Bytes 12/14/15 unchanged on a follow-up word read at adrs 12.
- Word write 0xDEADBEEF at adrs 62 -> bytes 62=0xEF, 63=0xBE, 0=0xAD, 1=0xDE (wrap). Word read at 62 returns 0xDEADBEEF.
- Erase -> mem_erase high exactly one cycle, rsp after 2 cycles. Subsequent word read at 0 returns 0x00000000.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid and rsp_data stable, req_ready=0, no memory activity. req_op=11 -> rsp_err=1 with no mem_mode/mem_erase pulse.
- Assert rst_n=0 during a word write's second byte -> all outputs at reset values asynchronously. After release, a read request completes normally.
